frame_loader: RTL

FRAME_LOADER -- requirements
Module: frame_loader

---
 rtl/frame_loader.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/frame_loader.sv
// Frame loader: turns a byte stream (SYNC, ID, payload, XOR checksum) into
// framebuffer writes, and reports whether each frame arrived intact.
module frame_loader #(
    parameter int unsigned FRAME_BYTES = 9600,
    parameter int unsigned ADDR_W      = 14,
    parameter logic [7:0]  SYNC_BYTE   = 8'hA5
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_rx_valid,
    input  logic [7:0]        i_rx_byte,
    output logic              o_fb_we,
    output logic [ADDR_W-1:0] o_fb_addr,
    output logic [7:0]        o_fb_wdata,
    output logic [7:0]        o_frame_id,
    output logic              o_frame_done,
    output logic              o_chk_err,
    output logic              o_busy
);

    // One extra bit so the counter can hold FRAME_BYTES even when it equals 2^ADDR_W.
    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_BYTES);

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StHdr     = 2'd1,
        StPayload = 2'd2,
        StCheck   = 2'd3
    } state_e;

    state_e             r_state;
    state_e             w_state_next;
    logic [7:0]         r_pend_id;
    logic [7:0]         w_pend_id_next;
    logic [CNT_W-1:0]   r_count;
    logic [CNT_W-1:0]   w_count_next;
    logic [CNT_W-1:0]   w_count_inc;
    logic [7:0]         r_checksum;
    logic [7:0]         w_checksum_next;
    logic               r_fb_we;
    logic               w_fb_we_next;
    logic [ADDR_W-1:0]  r_fb_addr;
    logic [ADDR_W-1:0]  w_fb_addr_next;
    logic [7:0]         r_fb_wdata;
    logic [7:0]         w_fb_wdata_next;
    logic [7:0]         r_frame_id;
    logic [7:0]         w_frame_id_next;
    logic               r_frame_done;
    logic               w_frame_done_next;
    logic               r_chk_err;
    logic               w_chk_err_next;

    assign w_count_inc = r_count + CNT_W'(1);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= StIdle;
            r_pend_id    <= 8'h00;
            r_count      <= '0;
            r_checksum   <= 8'h00;
            r_fb_we      <= 1'b0;
            r_fb_addr    <= '0;
            r_fb_wdata   <= 8'h00;
            r_frame_id   <= 8'h00;
            r_frame_done <= 1'b0;
            r_chk_err    <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_pend_id    <= w_pend_id_next;
            r_count      <= w_count_next;
            r_checksum   <= w_checksum_next;
            r_fb_we      <= w_fb_we_next;
            r_fb_addr    <= w_fb_addr_next;
            r_fb_wdata   <= w_fb_wdata_next;
            r_frame_id   <= w_frame_id_next;
            r_frame_done <= w_frame_done_next;
            r_chk_err    <= w_chk_err_next;
        end
    end

    always_comb begin
        w_state_next      = r_state;
        w_pend_id_next    = r_pend_id;
        w_count_next      = r_count;
        w_checksum_next   = r_checksum;
        w_fb_we_next      = 1'b0;
        w_fb_addr_next    = r_fb_addr;
        w_fb_wdata_next   = r_fb_wdata;
        w_frame_id_next   = r_frame_id;
        w_frame_done_next = 1'b0;
        w_chk_err_next    = 1'b0;

        // SYNC_BYTE only has meaning in idle; elsewhere it is plain data.
        if (i_rx_valid) begin
            unique case (r_state)
                StIdle: begin
                    if (i_rx_byte == SYNC_BYTE) begin
                        w_state_next = StHdr;
                    end
                end
                StHdr: begin
                    w_pend_id_next  = i_rx_byte;
                    w_count_next    = '0;
                    w_checksum_next = 8'h00;
                    w_state_next    = StPayload;
                end
                StPayload: begin
                    w_fb_we_next    = 1'b1;
                    w_fb_addr_next  = r_count[ADDR_W-1:0];
                    w_fb_wdata_next = i_rx_byte;
                    w_count_next    = w_count_inc;
                    w_checksum_next = r_checksum ^ i_rx_byte;
                    if (w_count_inc == LAST_CNT) begin
                        w_state_next = StCheck;
                    end
                end
                StCheck: begin
                    if (i_rx_byte == r_checksum) begin
                        w_frame_id_next   = r_pend_id;
                        w_frame_done_next = 1'b1;
                    end else begin
                        w_chk_err_next = 1'b1;
                    end
                    w_state_next = StIdle;
                end
                default: begin
                    w_state_next = StIdle;
                end
            endcase
        end
    end

    assign o_fb_we      = r_fb_we;
    assign o_fb_addr    = r_fb_addr;
    assign o_fb_wdata   = r_fb_wdata;
    assign o_frame_id   = r_frame_id;
    assign o_frame_done = r_frame_done;
    assign o_chk_err    = r_chk_err;
    assign o_busy       = (r_state != StIdle);

endmodule
